// File: rtl/arf132b192e1r1w0cbbehcaa4acw_pkg.sv
// Shared sizing constants and stage-1 pipeline record for the latch-array read port.
package arf132b192e1r1w0cbbehcaa4acw_pkg;

    localparam int unsigned ENTRIES = 192;
    localparam int unsigned WIDTH   = 132;
    localparam int unsigned ADR_W   = 8;
    localparam int unsigned CNT_W   = 16;

    typedef struct packed {
        logic             vld;
        logic [ADR_W-1:0] adr;
        logic             oor;
        logic             hit;
        logic [WIDTH-1:0] bdata;
    } s1_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_rd_byp.sv
// Read-address range check and same-cycle write/read address compare.
module arf132b192e1r1w0cbbehcaa4acw_rd_byp #(
    parameter int unsigned ENTRIES = arf132b192e1r1w0cbbehcaa4acw_pkg::ENTRIES,
    parameter int unsigned ADR_W   = arf132b192e1r1w0cbbehcaa4acw_pkg::ADR_W
) (
    input  logic             rd_en,
    input  logic [ADR_W-1:0] rd_adr,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    output logic             rd_oor,
    output logic             byp_hit
);

    // One extra bit so ENTRIES == 2**ADR_W still compares correctly.
    localparam logic [ADR_W:0] LIMIT = (ADR_W+1)'(ENTRIES);

    logic wr_oor;

    always_comb begin
        rd_oor  = ({1'b0, rd_adr} >= LIMIT);
        wr_oor  = ({1'b0, wr_adr} >= LIMIT);
        byp_hit = rd_en & wr_en & ~rd_oor & ~wr_oor & (rd_adr == wr_adr);
    end

endmodule

// File: rtl/arf132b192e1r1w0cbbehcaa4acw_rd_port.sv
// Two-stage read port for a 1R1W latch array with write-first bypass of same-cycle writes.
module arf132b192e1r1w0cbbehcaa4acw_rd_port #(
    parameter int unsigned ENTRIES = arf132b192e1r1w0cbbehcaa4acw_pkg::ENTRIES,
    parameter int unsigned WIDTH   = arf132b192e1r1w0cbbehcaa4acw_pkg::WIDTH,
    parameter int unsigned ADR_W   = arf132b192e1r1w0cbbehcaa4acw_pkg::ADR_W,
    parameter int unsigned CTECH   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_en,
    input  logic [ADR_W-1:0] rd_adr,
    input  logic             wr_en,
    input  logic [ADR_W-1:0] wr_adr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [ADR_W-1:0] arr_rd_adr,
    input  logic [WIDTH-1:0] arr_rdata,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_err,
    output logic [15:0]      byp_cnt
);

    import arf132b192e1r1w0cbbehcaa4acw_pkg::s1_t;
    import arf132b192e1r1w0cbbehcaa4acw_pkg::sat_inc;

    logic             rd_oor;
    logic             byp_hit;
    s1_t              s1_d, s1_q;
    logic             rd_vld_d, rd_vld_q;
    logic             rd_err_d, rd_err_q;
    logic [WIDTH-1:0] rd_data_d, rd_data_q;
    logic [15:0]      byp_cnt_d, byp_cnt_q;

    arf132b192e1r1w0cbbehcaa4acw_rd_byp #(
        .ENTRIES (ENTRIES),
        .ADR_W   (ADR_W)
    ) u_rd_byp (
        .rd_en   (rd_en),
        .rd_adr  (rd_adr),
        .wr_en   (wr_en),
        .wr_adr  (wr_adr),
        .rd_oor  (rd_oor),
        .byp_hit (byp_hit)
    );

    // A write one cycle earlier is already in the array when stage 2 samples it,
    // so only a same-cycle write needs its data captured here.
    always_comb begin
        s1_d     = s1_q;
        s1_d.vld = rd_en;
        s1_d.oor = rd_oor;
        s1_d.hit = byp_hit;
        if (rd_en) begin
            s1_d.adr = rd_adr;
        end
        if (byp_hit) begin
            s1_d.bdata = wr_data;
        end
    end

    if (CTECH != 0) begin : g_s1_ctech
        // No ctech flop cell is mapped for this record; an inferred flop is used.
        always_ff @(posedge clk) begin
            if (rst) s1_q <= '0;
            else     s1_q <= s1_d;
        end
    end else begin : g_s1_rtl
        always_ff @(posedge clk) begin
            if (rst) s1_q <= '0;
            else     s1_q <= s1_d;
        end
    end

    always_comb begin
        rd_vld_d  = s1_q.vld;
        rd_err_d  = s1_q.vld & s1_q.oor;
        rd_data_d = rd_data_q;
        byp_cnt_d = byp_cnt_q;
        if (s1_q.vld) begin
            if (s1_q.oor)      rd_data_d = '0;
            else if (s1_q.hit) rd_data_d = s1_q.bdata;
            else               rd_data_d = arr_rdata;
            if (s1_q.hit) begin
                byp_cnt_d = sat_inc(byp_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
            byp_cnt_q <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
            byp_cnt_q <= byp_cnt_d;
        end
    end

    assign arr_rd_adr = s1_q.adr;
    assign rd_vld     = rd_vld_q;
    assign rd_err     = rd_err_q;
    assign rd_data    = rd_data_q;
    assign byp_cnt    = byp_cnt_q;

endmodule

// File: tb/tb_arf132b192e1r1w0cbbehcaa4acw_rd_port.sv
// Scoreboard bench for the read port, with a behavioural latch array (2-cycle write commit).
module tb_arf132b192e1r1w0cbbehcaa4acw_rd_port;

    import arf132b192e1r1w0cbbehcaa4acw_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_en;
    logic [ADR_W-1:0] rd_adr;
    logic             wr_en;
    logic [ADR_W-1:0] wr_adr;
    logic [WIDTH-1:0] wr_data;
    logic [ADR_W-1:0] arr_rd_adr;
    logic [WIDTH-1:0] arr_rdata;
    logic             rd_vld;
    logic [WIDTH-1:0] rd_data;
    logic             rd_err;
    logic [15:0]      byp_cnt;

    typedef struct {
        int               cyc;
        logic             err;
        logic [WIDTH-1:0] data;
        logic [15:0]      byp;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic [15:0]      byp_model = '0;

    logic [WIDTH-1:0] mem [ENTRIES];
    logic             wq_en = 1'b0;
    logic [ADR_W-1:0] wq_adr = '0;
    logic [WIDTH-1:0] wq_data = '0;
    logic             fill = 1'b0;
    logic             bd_en = 1'b0;
    logic [ADR_W-1:0] bd_adr = '0;
    logic [WIDTH-1:0] bd_data = '0;
    logic             mon_on = 1'b0;
    logic             rst_at_edge = 1'b1;
    logic [WIDTH-1:0] last_data = '0;

    arf132b192e1r1w0cbbehcaa4acw_rd_port #(
        .ENTRIES (ENTRIES),
        .WIDTH   (WIDTH),
        .ADR_W   (ADR_W),
        .CTECH   (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rd_en      (rd_en),
        .rd_adr     (rd_adr),
        .wr_en      (wr_en),
        .wr_adr     (wr_adr),
        .wr_data    (wr_data),
        .arr_rd_adr (arr_rd_adr),
        .arr_rdata  (arr_rdata),
        .rd_vld     (rd_vld),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .byp_cnt    (byp_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] pat(input int i);
        return {4'h9, 64'(i) * 64'h0101, 64'(i)};
    endfunction

    // Array: a write sampled at edge t lands one edge later, readable from cycle t+2.
    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
        wq_en       <= wr_en;
        wq_adr      <= wr_adr;
        wq_data     <= wr_data;
        if (fill) begin
            for (int i = 0; i < ENTRIES; i++) mem[ADR_W'(i)] <= pat(i);
        end
        if (bd_en) mem[bd_adr] <= bd_data;
        if (wq_en && wq_adr < ADR_W'(ENTRIES)) mem[wq_adr] <= wq_data;
    end

    assign arr_rdata = (arr_rd_adr < ADR_W'(ENTRIES)) ? mem[arr_rd_adr] : '0;

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            if (rd_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rd_vld", WIDTH'(rd_vld), '0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("latency", WIDTH'(cyc), WIDTH'(mon_e.cyc + 2));
                    chk("rd_data", rd_data, mon_e.data);
                    chk("rd_err", WIDTH'(rd_err), WIDTH'(mon_e.err));
                    chk("byp_cnt", WIDTH'(byp_cnt), WIDTH'(mon_e.byp));
                end
            end else begin
                chk("idle_rd_err", WIDTH'(rd_err), '0);
                if (!rst_at_edge) chk("idle_hold", rd_data, last_data);
            end
        end
        last_data = rd_data;
    end

    task automatic issue(input bit rd, input int radr, input bit wr, input int wadr,
                         input logic [WIDTH-1:0] wdata, input logic [WIDTH-1:0] edata,
                         input bit eerr, input bit ehit);
        rd_en   = rd;
        rd_adr  = ADR_W'(radr);
        wr_en   = wr;
        wr_adr  = ADR_W'(wadr);
        wr_data = wdata;
        if (rd) begin
            if (ehit && byp_model != 16'hFFFF) byp_model = byp_model + 16'd1;
            sb.push_back('{cyc, eerr, edata, byp_model});
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        rd_en = 1'b0;
        wr_en = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst = 1'b1; rd_en = 1'b0; wr_en = 1'b0;
        rd_adr = '0; wr_adr = '0; wr_data = '0;
        fill = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; fill = 1'b0; mon_on = 1'b1;

        @(negedge clk);
        chk("reset_rd_vld", WIDTH'(rd_vld), '0);
        chk("reset_rd_err", WIDTH'(rd_err), '0);
        chk("reset_rd_data", rd_data, '0);
        chk("reset_byp_cnt", WIDTH'(byp_cnt), '0);
        chk("reset_arr_rd_adr", WIDTH'(arr_rd_adr), '0);
        @(posedge clk); #1;

        // back-to-back sweep of every row
        for (int i = 0; i < ENTRIES; i++) issue(1, i, 0, 0, '0, pat(i), 0, 0);
        idle(1);

        bd_en = 1'b1; bd_adr = 8'd5; bd_data = WIDTH'(8'hA5);
        @(posedge clk); #1;
        bd_adr = 8'd7; bd_data = WIDTH'(8'h11);
        @(posedge clk); #1;
        bd_en = 1'b0;

        issue(1, 5, 0, 0, '0, WIDTH'(8'hA5), 0, 0);
        issue(1, 7, 1, 7, WIDTH'(8'h3C), WIDTH'(8'h3C), 0, 1);
        issue(0, 0, 1, 9, WIDTH'(8'h77), '0, 0, 0);
        issue(1, 9, 0, 0, '0, WIDTH'(8'h77), 0, 0);
        issue(0, 0, 1, 9, WIDTH'(8'h55), '0, 0, 0);
        issue(1, 12, 1, 9, WIDTH'(8'h66), pat(12), 0, 0);
        idle(2);
        issue(1, 9, 0, 0, '0, WIDTH'(8'h66), 0, 0);
        issue(1, 200, 1, 200, WIDTH'(8'hEE), '0, 1, 0);
        issue(1, 192, 1, 192, WIDTH'(8'hEE), '0, 1, 0);
        issue(1, 191, 1, 191, WIDTH'(8'hBB), WIDTH'(8'hBB), 0, 1);
        issue(1, 255, 0, 0, '0, '0, 1, 0);
        issue(1, 7, 0, 0, '0, WIDTH'(8'h3C), 0, 0);
        issue(1, 5, 1, 200, WIDTH'(8'hCC), WIDTH'(8'hA5), 0, 0);
        idle(3);

        // bypassed read in flight when reset hits; rd_en during reset is ignored
        rd_en = 1'b1; rd_adr = 8'd7; wr_en = 1'b1; wr_adr = 8'd7; wr_data = WIDTH'(8'h12);
        @(posedge clk); #1;
        rst = 1'b1; rd_en = 1'b1; rd_adr = 8'd3; wr_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rd_en = 1'b0;
        byp_model = '0;
        @(negedge clk);
        chk("post_rst_rd_vld", WIDTH'(rd_vld), '0);
        chk("post_rst_byp_cnt", WIDTH'(byp_cnt), '0);
        chk("post_rst_rd_data", rd_data, '0);
        chk("post_rst_arr_rd_adr", WIDTH'(arr_rd_adr), '0);
        @(posedge clk); #1;
        idle(3);

        // drive the bypass counter to saturation and past it
        for (int k = 0; k < 65537; k++) issue(1, 11, 1, 11, {4'h5, 128'(k)}, {4'h5, 128'(k)}, 0, 1);
        idle(3);
        @(negedge clk);
        chk("byp_cnt_saturated", WIDTH'(byp_cnt), WIDTH'(16'hFFFF));

        for (int t = 0; t < 20 && sb.size() != 0; t++) @(posedge clk);
        chk("scoreboard_drained", WIDTH'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
